keypad_matrix_scanner: RTL

Drives the row lines of a 4x3 membrane keypad one row at a time and samples the column return lines. It debounces the result. It presents a stable one-hot row/column pair (row1..row4, col1..col3) to the keypad-to-BCD encoder stage. It sits between the physical keypad pins and the BCD datapath, and adds key_valid and key_press qualifiers so downstream logic never sees bounce, ghost or multi-key codes.

---
 rtl/keypad_matrix_scanner.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad row scanner with column synchronizer, per-scan classification and
// scan-level debounce; presents a one-hot row/col pair plus key_valid/key_press.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] col_in,
    output logic [3:0] row_drive,
    output logic       row1,
    output logic       row2,
    output logic       row3,
    output logic       row4,
    output logic       col1,
    output logic       col2,
    output logic       col3,
    output logic       key_valid,
    output logic       key_press
);

    // state    | meaning
    // IDLE     | no key held, waiting for a SINGLE scan
    // DEBOUNCE | candidate seen, counting matching scans
    // PRESSED  | key accepted, outputs driven
    // RELEASE  | held key missing, counting non-matching scans
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam int             DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB_N      = 4'(DEBOUNCE_SCANS);

    state_t        state_q;
    logic [2:0]    col_meta_q, col_s_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    row_idx_q;
    logic [3:0]    row_drive_q;
    logic [3:0]    cnt_q;
    logic [1:0]    cand_row_q;
    logic [2:0]    cand_col_q;
    logic          hit_q, multi_q;
    logic [1:0]    row_hit_q;
    logic [2:0]    col_hit_q;
    logic [3:0]    row_oh_q;
    logic [2:0]    col_oh_q;
    logic          key_valid_q, key_press_q;

    logic          hit_d, multi_d;
    logic [1:0]    row_hit_d;
    logic [2:0]    col_hit_d;
    logic          sample_en, scan_end;
    logic          col_nz, col_onehot;
    logic          res_single, same_key;
    logic [3:0]    cnt_inc;

    assign sample_en  = (dwell_q == DWELL_LAST);
    assign scan_end   = sample_en && (row_idx_q == 2'd3);
    assign col_nz     = |col_s_q;
    assign col_onehot = col_nz && ((col_s_q & (col_s_q - 3'd1)) == 3'd0);
    assign cnt_inc    = cnt_q + 4'd1;

    // Scan accumulator including the sample taken on this edge.
    always_comb begin
        hit_d     = hit_q;
        multi_d   = multi_q;
        row_hit_d = row_hit_q;
        col_hit_d = col_hit_q;
        if (sample_en && col_nz) begin
            if (hit_q || !col_onehot) begin
                multi_d = 1'b1;
            end else begin
                hit_d     = 1'b1;
                row_hit_d = row_idx_q;
                col_hit_d = col_s_q;
            end
        end
    end

    assign res_single = hit_d && !multi_d;
    assign same_key   = res_single && (row_hit_d == cand_row_q) && (col_hit_d == cand_col_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            col_meta_q  <= '0;
            col_s_q     <= '0;
            dwell_q     <= '0;
            row_idx_q   <= '0;
            row_drive_q <= 4'b0001;
            cnt_q       <= '0;
            cand_row_q  <= '0;
            cand_col_q  <= '0;
            hit_q       <= 1'b0;
            multi_q     <= 1'b0;
            row_hit_q   <= '0;
            col_hit_q   <= '0;
            row_oh_q    <= '0;
            col_oh_q    <= '0;
            key_valid_q <= 1'b0;
            key_press_q <= 1'b0;
        end else begin
            col_meta_q  <= col_in;
            col_s_q     <= col_meta_q;
            key_press_q <= 1'b0;

            if (sample_en) begin
                dwell_q     <= '0;
                row_idx_q   <= row_idx_q + 2'd1;
                row_drive_q <= {row_drive_q[2:0], row_drive_q[3]};
            end else begin
                dwell_q <= dwell_q + 1'b1;
            end

            if (scan_end) begin
                hit_q     <= 1'b0;
                multi_q   <= 1'b0;
                row_hit_q <= '0;
                col_hit_q <= '0;
            end else if (sample_en) begin
                hit_q     <= hit_d;
                multi_q   <= multi_d;
                row_hit_q <= row_hit_d;
                col_hit_q <= col_hit_d;
            end

            if (scan_end) begin
                case (state_q)
                    IDLE: begin
                        if (res_single) begin
                            cand_row_q <= row_hit_d;
                            cand_col_q <= col_hit_d;
                            if (DEB_N == 4'd1) begin
                                state_q     <= PRESSED;
                                cnt_q       <= '0;
                                row_oh_q    <= 4'b0001 << row_hit_d;
                                col_oh_q    <= col_hit_d;
                                key_valid_q <= 1'b1;
                                key_press_q <= 1'b1;
                            end else begin
                                state_q <= DEBOUNCE;
                                cnt_q   <= 4'd1;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    DEBOUNCE: begin
                        if (same_key) begin
                            if (cnt_inc >= DEB_N) begin
                                state_q     <= PRESSED;
                                cnt_q       <= '0;
                                row_oh_q    <= 4'b0001 << row_hit_d;
                                col_oh_q    <= col_hit_d;
                                key_valid_q <= 1'b1;
                                key_press_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else if (res_single) begin
                            cand_row_q <= row_hit_d;
                            cand_col_q <= col_hit_d;
                            cnt_q      <= 4'd1;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (same_key) begin
                            cnt_q <= '0;
                        end else if (DEB_N == 4'd1) begin
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                            row_oh_q    <= '0;
                            col_oh_q    <= '0;
                            key_valid_q <= 1'b0;
                        end else begin
                            state_q <= RELEASE;
                            cnt_q   <= 4'd1;
                        end
                    end
                    RELEASE: begin
                        if (same_key) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_inc >= DEB_N) begin
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                            row_oh_q    <= '0;
                            col_oh_q    <= '0;
                            key_valid_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign row_drive = row_drive_q;
    assign row1      = row_oh_q[0];
    assign row2      = row_oh_q[1];
    assign row3      = row_oh_q[2];
    assign row4      = row_oh_q[3];
    assign col1      = col_oh_q[0];
    assign col2      = col_oh_q[1];
    assign col3      = col_oh_q[2];
    assign key_valid = key_valid_q;
    assign key_press = key_press_q;

endmodule
